dp_ram_fifo_ctrl: RTL and testbench



---
 rtl/dp_ram_pkg.sv | 9 +
 rtl/dp_ram_out_skid.sv | 65 ++++++
 rtl/dp_ram_fifo_ctrl.sv | 129 ++++++++++++
 tb/tb_dp_ram_fifo_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared defaults for the 16x8 dual-port RAM and the FIFO controller that sequences it.
// Optional watermark outputs on the controller are enabled with DP_RAM_CTRL_WMARK_EN.
package dp_ram_pkg;
    localparam int DP_ADDR_W = 4;
    localparam int DP_DATA_W = 8;
    localparam int DP_DEPTH  = 1 << DP_ADDR_W;
    // Level counts RAM words plus one in-flight fetch plus two buffered words.
    localparam int DP_LVL_W  = DP_ADDR_W + 2;
endpackage

// File: rtl/dp_ram_out_skid.sv
// Two-entry FIFO-ordered output buffer that absorbs the one-cycle RAM read latency.
// The head entry is always slot 0, so out_data never moves while it is not popped.
module dp_ram_out_skid #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic [1:0]        count_o,
    output logic [DATA_W-1:0] head_o
);
    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;
    logic [1:0]        cnt_q, cnt_d;

    // Next-state: shift toward slot 0 on pop, fill the first free slot on push.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_d = push_data_i;
                    else               ent1_d = push_data_i;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0_d = push_data_i;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage and count; entries reset too so out_data reads 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = ent0_q;
endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// Circular-buffer FIFO controller around dp_ram with valid/ready on both sides.
// Owns write/read pointers and occupancy; prefetches up to two words into an output buffer.
// Define DP_RAM_CTRL_WMARK_EN to add registered almost_full / almost_empty outputs.
module dp_ram_fifo_ctrl
    import dp_ram_pkg::*;
#(
    parameter int ADDR_W = DP_ADDR_W,
    parameter int DATA_W = DP_DATA_W
`ifdef DP_RAM_CTRL_WMARK_EN
    ,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
`endif
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic [DATA_W-1:0] ram_w_data,
    output logic [ADDR_W-1:0] ram_r_addr,
    input  logic [DATA_W-1:0] ram_r_data,
    output logic [ADDR_W+1:0] level
`ifdef DP_RAM_CTRL_WMARK_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);
    localparam int LVL_W = ADDR_W + 2;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   mem_cnt_q, mem_cnt_d;
    logic              fetch_pend_q, fetch_pend_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [1:0]        ost_cnt, ost_cnt_d;
    logic              accept, issue, pop, push;
    logic [2:0]        occ;

    // Handshakes; the MSB of mem_cnt is set exactly when the RAM holds DEPTH words.
    assign in_ready  = sys_rst_n && !flush && !mem_cnt_q[ADDR_W];
    assign accept    = in_valid && in_ready;
    assign out_valid = (ost_cnt != 2'd0);
    assign pop       = out_valid && out_ready && !flush;
    assign push      = fetch_pend_q && !flush;

    // Issue only if the buffer slot is guaranteed once the fetch lands.
    assign occ   = {1'b0, ost_cnt} + {2'b00, fetch_pend_q};
    assign issue = !flush && (mem_cnt_q != '0) && (pop ? (occ < 3'd3) : (occ < 3'd2));

    assign ram_w_en   = accept;
    assign ram_w_addr = wr_ptr_q;
    assign ram_w_data = in_data;
    assign ram_r_addr = rd_ptr_q;

    // Next-state for pointers and counters; flush wipes everything including a pending fetch.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + ADDR_W'(accept);
        rd_ptr_d     = rd_ptr_q + ADDR_W'(issue);
        mem_cnt_d    = mem_cnt_q + (ADDR_W+1)'(accept) - (ADDR_W+1)'(issue);
        fetch_pend_d = issue;
        ost_cnt_d    = ost_cnt + 2'(push) - 2'(pop);
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            mem_cnt_d    = '0;
            fetch_pend_d = 1'b0;
            ost_cnt_d    = 2'd0;
        end
        level_d = LVL_W'(mem_cnt_d) + LVL_W'(fetch_pend_d) + LVL_W'(ost_cnt_d);
    end

    // Pointer, occupancy, fetch-pending and level registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_cnt_q    <= '0;
            fetch_pend_q <= 1'b0;
            level_q      <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_cnt_q    <= mem_cnt_d;
            fetch_pend_q <= fetch_pend_d;
            level_q      <= level_d;
        end
    end

    assign level = level_q;

    dp_ram_out_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i       (sys_clk),
        .rst_ni      (sys_rst_n),
        .flush_i     (flush),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (ram_r_data),
        .count_o     (ost_cnt),
        .head_o      (out_data)
    );

`ifdef DP_RAM_CTRL_WMARK_EN
    logic afull_q, aempty_q;

    // Watermarks follow the registered level by one cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            afull_q  <= (level_q >= LVL_W'(AFULL_TH));
            aempty_q <= (level_q <= LVL_W'(AEMPTY_TH));
        end
    end

    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
`endif
endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Testbench for dp_ram_fifo_ctrl: directed phases plus a randomized phase, compared every
// cycle against a queue-based behavioural model. Contains a behavioural dp_ram stand-in.
module tb_dp_ram_fifo_ctrl;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       ram_w_en;
    logic [3:0] ram_w_addr;
    logic [7:0] ram_w_data;
    logic [3:0] ram_r_addr;
    logic [7:0] ram_r_data;
    logic [5:0] level;
    logic       almost_full;
    logic       almost_empty;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    dp_ram_fifo_ctrl dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .ram_w_en     (ram_w_en),
        .ram_w_addr   (ram_w_addr),
        .ram_w_data   (ram_w_data),
        .ram_r_addr   (ram_r_addr),
        .ram_r_data   (ram_r_data),
        .level        (level)
`ifdef DP_RAM_CTRL_WMARK_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

`ifndef DP_RAM_CTRL_WMARK_EN
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b1;
`endif

    // Behavioural 16x8 dual-port RAM with registered read, both ports on sys_clk.
    logic [7:0] ram_mem [16];
    always @(posedge sys_clk) begin
        if (ram_w_en) ram_mem[ram_w_addr] <= ram_w_data;
        ram_r_data <= ram_mem[ram_r_addr];
    end

    // Reference model: words in RAM, one optional word in flight, output buffer.
    logic [7:0] m_mem[$];
    logic [7:0] m_ob[$];
    bit         m_fv;
    logic [7:0] m_fd;
    int         m_wr, m_rd;
    bit         m_af, m_ae;

    function automatic int m_level();
        return m_mem.size() + int'(m_fv) + m_ob.size();
    endfunction

    task automatic m_reset();
        m_mem.delete();
        m_ob.delete();
        m_fv = 0;
        m_fd = 8'h00;
        m_wr = 0;
        m_rd = 0;
        m_af = 0;
        m_ae = 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven: check, advance model, move to next cycle.
    task automatic tick();
        bit ir, acc, pop, iss, nfv;
        logic [7:0] nfd;
        int lvl;
        #3;
        ir  = !flush && (m_mem.size() < 16);
        acc = in_valid && ir;
        chk("in_ready", in_ready, ir);
        chk("out_valid", out_valid, m_ob.size() > 0);
        if (m_ob.size() > 0) chk("out_data", out_data, m_ob[0]);
        chk("level", level, m_level());
        chk("ram_w_en", ram_w_en, acc);
        if (acc) begin
            chk("ram_w_addr", ram_w_addr, m_wr);
            chk("ram_w_data", ram_w_data, in_data);
        end
        chk("ram_r_addr", ram_r_addr, m_rd);
`ifdef DP_RAM_CTRL_WMARK_EN
        chk("almost_full", almost_full, m_af);
        chk("almost_empty", almost_empty, m_ae);
`endif
        lvl = m_level();
        if (flush) begin
            m_mem.delete();
            m_ob.delete();
            m_fv = 0;
            m_wr = 0;
            m_rd = 0;
        end else begin
            pop = (m_ob.size() > 0) && out_ready;
            iss = (m_mem.size() > 0) && ((m_ob.size() + int'(m_fv) - int'(pop)) < 2);
            if (pop) void'(m_ob.pop_front());
            if (m_fv) m_ob.push_back(m_fd);
            nfv = iss;
            nfd = m_fd;
            if (iss) begin
                nfd  = m_mem.pop_front();
                m_rd = (m_rd + 1) % 16;
            end
            if (acc) begin
                m_mem.push_back(in_data);
                m_wr = (m_wr + 1) % 16;
            end
            m_fv = nfv;
            m_fd = nfd;
        end
        m_af = (lvl >= 12);
        m_ae = (lvl <= 2);
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] d;
        m_reset();

        // Reset state with in_valid high: nothing may be accepted.
        in_valid = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_level", level, 6'd0);
        chk("rst_ram_w_en", ram_w_en, 1'b0);
        chk("rst_ram_w_addr", ram_w_addr, 4'd0);
        chk("rst_ram_r_addr", ram_r_addr, 4'd0);
        chk("rst_almost_full", almost_full, 1'b0);
        chk("rst_almost_empty", almost_empty, 1'b1);
        in_valid  = 1'b0;
        sys_rst_n = 1'b1;

        // Seven words back-to-back with the consumer stalled.
        for (int i = 1; i <= 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("seven_level", level, 6'd7);
        chk("seven_head", out_data, 8'h01);

        // Drain continuously.
        out_ready = 1'b1;
        repeat (10) tick();
        chk("seven_drained", level, 6'd0);

        // Fill past DEPTH with the consumer stalled, then drain across the wrap.
        out_ready = 1'b0;
        for (int i = 0; i < 22; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h40 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("full_level", level, 6'd18);
        chk("full_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        repeat (22) tick();
        chk("full_drained", level, 6'd0);

        // Streaming: simultaneous write and read for 40 cycles.
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h80 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();

        // Flush while a fetch is in flight at level 5.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pre_flush_level", level, 6'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("post_flush_level", level, 6'd0);
        chk("post_flush_valid", out_valid, 1'b0);
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("a5_seen", out_valid, 1'b1);
        chk("a5_data", out_data, 8'hA5);
        out_ready = 1'b1;
        repeat (3) tick();

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 45);
            flush     = ($urandom_range(0, 59) == 0);
            d         = 8'($urandom);
            in_data   = d;
            tick();
        end
        flush = 1'b0;

        // Asynchronous reset pulse in the middle of streaming.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'hC0 + 8'(i);
            tick();
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_data", out_data, 8'h00);
        chk("arst_level", level, 6'd0);
        chk("arst_ram_w_en", ram_w_en, 1'b0);
        chk("arst_ram_w_addr", ram_w_addr, 4'd0);
        chk("arst_ram_r_addr", ram_r_addr, 4'd0);
        chk("arst_almost_full", almost_full, 1'b0);
        chk("arst_almost_empty", almost_empty, 1'b1);
        m_reset();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_data = 8'hE0 + 8'(i);
            tick();
        end
        in_valid  = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (20) tick();
        chk("final_level", level, 6'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
